// File: rtl/datapath_pkg.sv
// Shared constants for the multi-cycle MIPS datapath.
// Used by the register file, destination mux and control unit.
package datapath_pkg;

  localparam int          DATA_W   = 32;
  localparam int          NUM_REGS = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [4:0]  REG_RA   = 5'd31;

endpackage

// File: rtl/register_bank.sv
// 32-entry general-purpose register file, two async reads, one write.
// $zero is hardwired; $sp resets to the top of data memory.
module register_bank #(
  parameter int          DATA_W  = 32,
  parameter int unsigned SP_INIT = 227,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WriteDone
);

  import datapath_pkg::*;

  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Zero and bypass take priority over stored contents.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0] addr
  );
    logic hit;
    hit = BYPASS && RegWrite
       && (WriteReg != REG_ZERO)
       && (addr == WriteReg);
    if (addr == REG_ZERO)
      return '0;
    else if (hit)
      return WriteData;
    else
      return regs[addr];
  endfunction

  // Storage update: reset wins over any write in the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      regs[REG_SP] <= SP_VAL;
      WriteDone    <= 1'b0;
    end else begin
      WriteDone <= RegWrite;
      if (RegWrite && (WriteReg != REG_ZERO))
        regs[WriteReg] <= WriteData;
    end
  end

  // Both read ports share the same lookup.
  always_comb begin
    ReadData1 = read_port(ReadReg1);
    ReadData2 = read_port(ReadReg2);
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank, bypass and non-bypass builds.
// Directed scenarios followed by randomized traffic against a model.
module tb_register_bank;

  localparam int W = 32;
  localparam int SPI = 227;

  logic         clk;
  logic         reset_n;
  logic         RegWrite;
  logic [4:0]   ReadReg1;
  logic [4:0]   ReadReg2;
  logic [4:0]   WriteReg;
  logic [W-1:0] WriteData;
  logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic         wdone_b, wdone_n;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] model [32];
  logic         exp_done;

  register_bank #(.DATA_W(W), .SP_INIT(SPI), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteDone(wdone_b)
  );

  register_bank #(.DATA_W(W), .SP_INIT(SPI), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteDone(wdone_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] expect_rd(
    input logic [4:0] a, input bit byp
  );
    if (a == 5'd0) return '0;
    if (byp && RegWrite && WriteReg != 5'd0 && a == WriteReg)
      return WriteData;
    return model[a];
  endfunction

  task automatic check(
    input string tag, input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "/b.rd1"}, rd1_b, expect_rd(ReadReg1, 1'b1));
    check({tag, "/b.rd2"}, rd2_b, expect_rd(ReadReg2, 1'b1));
    check({tag, "/n.rd1"}, rd1_n, expect_rd(ReadReg1, 1'b0));
    check({tag, "/n.rd2"}, rd2_n, expect_rd(ReadReg2, 1'b0));
  endtask

  task automatic check_done(input string tag);
    check({tag, "/b.done"}, W'(wdone_b), W'(exp_done));
    check({tag, "/n.done"}, W'(wdone_n), W'(exp_done));
  endtask

  task automatic tick();
    logic         r, we;
    logic [4:0]   wa;
    logic [W-1:0] wd;
    r = reset_n; we = RegWrite; wa = WriteReg; wd = WriteData;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[29] = W'(SPI);
      exp_done = 1'b0;
    end else begin
      exp_done = we;
      if (we && wa != 5'd0) model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    exp_done = 1'b0;
    reset_n = 1'b0; RegWrite = 1'b0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    WriteReg = 5'd0; WriteData = '0;
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    // 1. reset state
    ReadReg1 = 5'd29; ReadReg2 = 5'd7; #1;
    check("reset.sp", rd1_b, 32'd227);
    check("reset.r7", rd2_b, 32'd0);
    check_reads("reset");
    check_done("reset");

    // 2. write then read
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
    ReadReg2 = 5'd8; #1;
    check_reads("wr8.cyc");
    tick();
    RegWrite = 1'b0; #1;
    check("wr8.rd2", rd2_n, 32'hDEADBEEF);
    check_reads("wr8.after");
    check_done("wr8.pulse");
    tick();
    check_done("wr8.clear");

    // 3. $zero
    ReadReg1 = 5'd0; #1;
    check("zero.before", rd1_b, 32'd0);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; #1;
    check("zero.during", rd1_b, 32'd0);
    check_reads("zero.during");
    tick();
    RegWrite = 1'b0; #1;
    check("zero.after", rd1_b, 32'd0);
    check_reads("zero.after");
    check_done("zero.pulse");

    // 4. bypass on $ra, both ports
    ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h00400010; #1;
    check("byp.b1", rd1_b, 32'h00400010);
    check("byp.b2", rd2_b, 32'h00400010);
    check("byp.n1", rd1_n, 32'h0);
    check_reads("byp");
    tick();
    RegWrite = 1'b0; #1;
    check("byp.n.after", rd1_n, 32'h00400010);
    check_reads("byp.after");

    // 5. reset while a write is presented
    RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h100;
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd29; #1;
    check("sp.100", rd1_n, 32'h100);
    RegWrite = 1'b1; WriteData = 32'd5; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; RegWrite = 1'b0; #1;
    check("rstwr.sp", rd1_n, 32'd227);
    check("rstwr.done", W'(wdone_n), W'(1'b0));
    check_reads("rstwr");
    check_done("rstwr");

    // 6. sweep
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = W'(i * 4 + 1);
      tick();
    end
    RegWrite = 1'b0; #1;
    check_done("sweep.last");
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i); #1;
      check("sweep.val", rd1_n, (i == 0) ? W'(0) : W'(i * 4 + 1));
      check_reads("sweep");
    end

    // 7. randomized traffic
    for (int k = 0; k < 300; k++) begin
      reset_n   = ($urandom_range(0, 39) != 0);
      RegWrite  = 1'($urandom_range(0, 1));
      WriteReg  = 5'($urandom);
      WriteData = $urandom;
      ReadReg1  = 5'($urandom);
      ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom);
      #1;
      check_reads("rand.pre");
      tick();
      check_done("rand.done");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
